// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Brief    : Instruction/data RAM responder for a single-cycle RV32 core with
//            a byte-stream image loader that holds the core in reset.
//            Optional macro: MEM_RESPONDER_BOUNDS_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [7:0]                    load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          core_reset,
    input  logic [31:0]                   PC,
    output logic [31:0]                   instruction,
    input  logic                          WE,
    input  logic [31:0]                   address_to_mem,
    input  logic [31:0]                   data_to_mem,
    output logic [31:0]                   data_from_mem,
    output logic [$clog2(IMEM_WORDS):0]   load_words,
    output logic                          bus_error
);

    localparam int                       c_IMEM_AW   = $clog2(IMEM_WORDS);
    localparam int                       c_DMEM_AW   = $clog2(DMEM_WORDS);
    localparam logic [c_IMEM_AW-1:0]     c_LAST_WPTR = c_IMEM_AW'(IMEM_WORDS - 1);
    localparam logic [c_IMEM_AW:0]       c_ONE_WORD  = (c_IMEM_AW + 1)'(1);
    localparam logic [31:0]              c_BAD_DATA  = 32'hDEADBEEF;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [1:0]               r_byte_cnt;
    logic [c_IMEM_AW-1:0]     r_wptr;
    logic [31:0]              r_asm;
    logic [31:0]              w_asm_next;
    logic [c_IMEM_AW:0]       r_load_words;
    logic                     r_core_reset;
    logic                     w_run;
    logic                     w_accept;
    logic                     w_word_write;
    logic                     w_store;
    logic                     w_i_oob;
    logic                     w_d_oob;
    logic [c_IMEM_AW-1:0]     w_imem_idx;
    logic [c_DMEM_AW-1:0]     w_dmem_idx;
    logic                     w_unused_bits;

    logic [31:0] r_imem [IMEM_WORDS];
    logic [31:0] r_dmem [DMEM_WORDS];

    assign w_run        = (r_state == ST_RUN);
    assign load_ready   = (r_state == ST_LOAD);
    assign w_accept     = load_valid & load_ready & ~reset;
    assign w_word_write = w_accept & ((r_byte_cnt == 2'd3) | load_last);
    assign w_imem_idx   = PC[c_IMEM_AW+1:2];
    assign w_dmem_idx   = address_to_mem[c_DMEM_AW+1:2];
    assign w_unused_bits = ^{PC, address_to_mem};

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    assign w_i_oob = |PC[31:c_IMEM_AW+2];
    assign w_d_oob = |address_to_mem[31:c_DMEM_AW+2];
`else
    assign w_i_oob = 1'b0;
    assign w_d_oob = 1'b0;
`endif

    assign w_store = w_run & WE & ~w_d_oob & ~reset;

    // Incoming byte merged into its lane; lanes above it are still zero.
    always_comb begin
        w_asm_next = r_asm;
        case (r_byte_cnt)
            2'd0:    w_asm_next[7:0]   = load_data;
            2'd1:    w_asm_next[15:8]  = load_data;
            2'd2:    w_asm_next[23:16] = load_data;
            default: w_asm_next[31:24] = load_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_word_write && (load_last || (r_wptr == c_LAST_WPTR))) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt   <= 2'd0;
            r_wptr       <= '0;
            r_asm        <= 32'd0;
            r_load_words <= '0;
            r_core_reset <= 1'b1;
        end else begin
            r_core_reset <= ~w_run;
            if (w_word_write) begin
                r_byte_cnt   <= 2'd0;
                r_wptr       <= r_wptr + 1'b1;
                r_asm        <= 32'd0;
                r_load_words <= {1'b0, r_wptr} + c_ONE_WORD;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_asm      <= w_asm_next;
            end
        end
    end

    // RAM arrays carry no reset: contents survive a reload of the core.
    always_ff @(posedge clk) begin
        if (w_word_write) begin
            r_imem[r_wptr] <= w_asm_next;
        end
        if (w_store) begin
            r_dmem[w_dmem_idx] <= data_to_mem;
        end
    end

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    logic r_bus_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_error <= 1'b0;
        end else if (w_run && (w_i_oob || w_d_oob)) begin
            r_bus_error <= 1'b1;
        end
    end

    assign bus_error = r_bus_error;
`else
    assign bus_error = 1'b0;
`endif

    always_comb begin
        instruction   = NOP_WORD;
        data_from_mem = 32'd0;
        if (w_run) begin
            instruction   = w_i_oob ? c_BAD_DATA : r_imem[w_imem_idx];
            data_from_mem = w_d_oob ? c_BAD_DATA : r_dmem[w_dmem_idx];
        end
    end

    assign core_reset = r_core_reset;
    assign load_words = r_load_words;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        core_reset;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [6:0]  load_words;
    logic        bus_error;

    int total = 0;
    int bad   = 0;

    mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .core_reset     (core_reset),
        .PC             (PC),
        .instruction    (instruction),
        .WE             (WE),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem),
        .load_words     (load_words),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_data  = b;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        PC = 32'd0; WE = 1'b0; address_to_mem = 32'd0; data_to_mem = 32'd0;
        do_reset();

        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rst_load_words", {25'd0, load_words}, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
        chk("rst_instr_nop", instruction, 32'h00000013);
        chk("rst_dfm_zero", data_from_mem, 32'd0);

        // Full image: 259 bytes, byte i = i, never marked last.
        for (int i = 0; i < 259; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i);
            step();
            if (i == 254) chk("full_ready_before", {31'd0, load_ready}, 32'd1);
            if (i == 255) begin
                chk("full_ready_after", {31'd0, load_ready}, 32'd0);
                chk("full_words", {25'd0, load_words}, 32'd64);
            end
        end
        load_valid = 1'b0;
        chk("full_words_stable", {25'd0, load_words}, 32'd64);
        chk("full_core_run", {31'd0, core_reset}, 32'd0);
        PC = 32'h0; #1;
        chk("full_imem0", instruction, 32'h03020100);
        PC = 32'hFC; #1;
        chk("full_imem63", instruction, 32'hFFFEFDFC);

        // Two-word program with last on byte 8.
        do_reset();
        PC = 32'h0;
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'hA0, 1'b0); send(8'h00, 1'b0);
        send(8'h93, 1'b0); send(8'h05, 1'b0); send(8'h10, 1'b0);
        chk("prog_ready_pre", {31'd0, load_ready}, 32'd1);
        chk("prog_instr_nop", instruction, 32'h00000013);
        send(8'h00, 1'b1);
        chk("prog_run_ready", {31'd0, load_ready}, 32'd0);
        chk("prog_core_rst_hi", {31'd0, core_reset}, 32'd1);
        chk("prog_words", {25'd0, load_words}, 32'd2);
        step();
        chk("prog_core_rst_lo", {31'd0, core_reset}, 32'd0);
        PC = 32'h0; #1;
        chk("prog_imem0", instruction, 32'h00A00513);
        PC = 32'h4; #1;
        chk("prog_imem1", instruction, 32'h00100593);
        PC = 32'h7; #1;
        chk("prog_pc_lowbits", instruction, 32'h00100593);
        PC = 32'h8; #1;
        chk("prog_imem2_kept", instruction, 32'h0B0A0908);

        // Store: same-cycle read returns old data.
        address_to_mem = 32'h10; data_to_mem = 32'h11111111; WE = 1'b1;
        step();
        data_to_mem = 32'hCAFEF00D; #1;
        chk("st_old_data", data_from_mem, 32'h11111111);
        step();
        WE = 1'b0; #1;
        chk("st_new_data", data_from_mem, 32'hCAFEF00D);
        address_to_mem = 32'h0; data_to_mem = 32'h55AA55AA; WE = 1'b1;
        step();
        WE = 1'b0;

        // Out-of-range data address.
        address_to_mem = 32'h400; #1;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        chk("oob_read", data_from_mem, 32'hDEADBEEF);
        step();
        chk("oob_err_set", {31'd0, bus_error}, 32'd1);
        address_to_mem = 32'h0;
        step();
        chk("oob_err_sticky", {31'd0, bus_error}, 32'd1);
`else
        chk("oob_read_wrap", data_from_mem, 32'h55AA55AA);
        step();
        chk("oob_err_tied", {31'd0, bus_error}, 32'd0);
        address_to_mem = 32'h0;
        step();
        chk("oob_err_still0", {31'd0, bus_error}, 32'd0);
`endif

        // Reset; stores while loading are dropped; partial last word.
        do_reset();
        chk("rst2_bus_error", {31'd0, bus_error}, 32'd0);
        address_to_mem = 32'h10; #1;
        chk("load_dfm_zero", data_from_mem, 32'd0);
        data_to_mem = 32'h12345678; WE = 1'b1;
        step();
        WE = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        chk("part_words", {25'd0, load_words}, 32'd2);
        step();
        PC = 32'h0; #1;
        chk("part_imem0", instruction, 32'h04030201);
        PC = 32'h4; #1;
        chk("part_imem1", instruction, 32'h0000BBAA);
        chk("load_store_dropped", data_from_mem, 32'hCAFEF00D);

        // Reset in the middle of a load.
        do_reset();
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_ready", {31'd0, load_ready}, 32'd1);
        chk("midrst_core_rst", {31'd0, core_reset}, 32'd1);
        chk("midrst_words", {25'd0, load_words}, 32'd0);
        send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0); send(8'hD4, 1'b1);
        chk("midrst_new_words", {25'd0, load_words}, 32'd1);
        step();
        PC = 32'h0; #1;
        chk("midrst_imem0", instruction, 32'hD4C3B2A1);
        PC = 32'h4; #1;
        chk("midrst_imem1_kept", instruction, 32'h0000BBAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
